// File: rtl/control_sequencer.sv
// Hardwired Moore control unit sequencing T0..T6 fetch/execute for ALU, MUL/DIV, NOP and HALT.
// Optional SINGLE_STEP_EN: every fetch start additionally requires step==1 on that edge.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        step,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        PC_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        Read,
  output logic        IncPC,
  output logic [15:0] R0_15_enable,
  output logic [15:0] R0_15_out,
  output logic [4:0]  opcode,
  output logic        halted
);

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] fld_q, fld_d;  // {op, Ra, Rb, Rc} captured on the edge leaving T2

  logic       go;
  logic [4:0] dec_op;
  logic       dec_alu, dec_muldiv;
  logic [4:0] lat_op;
  logic [3:0] lat_ra, lat_rb, lat_rc;
  logic       lat_muldiv;
  logic       unused_bits;

  assign unused_bits = ^{ir[14:0], step};

`ifdef SINGLE_STEP_EN
  assign go = run & step;
`else
  assign go = run;
`endif

  assign dec_op     = ir[31:27];
  assign dec_muldiv = (dec_op == OP_MUL) || (dec_op == OP_DIV);
  assign dec_alu    = (dec_op <= 5'd14) || ((dec_op >= 5'd17) && (dec_op <= 5'd25));

  assign lat_op     = fld_q[16:12];
  assign lat_ra     = fld_q[11:8];
  assign lat_rb     = fld_q[7:4];
  assign lat_rc     = fld_q[3:0];
  assign lat_muldiv = (lat_op == OP_MUL) || (lat_op == OP_DIV);

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        fld_d = ir[31:15];
        if (dec_op == OP_HALT)            state_d = S_HALT;
        else if (dec_op == OP_NOP)        state_d = go ? S_T0 : S_IDLE;
        else if (dec_alu || dec_muldiv)   state_d = S_T3;
        else                              state_d = go ? S_T0 : S_IDLE;
      end
      S_T3:   state_d = S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = lat_muldiv ? S_T6 : (go ? S_T0 : S_IDLE);
      S_T6:   state_d = go ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCout        = 1'b0;
    ZLowout      = 1'b0;
    ZHighout     = 1'b0;
    MDRout       = 1'b0;
    PC_enable    = 1'b0;
    MAR_enable   = 1'b0;
    MDR_enable   = 1'b0;
    IR_enable    = 1'b0;
    Y_enable     = 1'b0;
    Z_enable     = 1'b0;
    HI_enable    = 1'b0;
    LO_enable    = 1'b0;
    Read         = 1'b0;
    IncPC        = 1'b0;
    R0_15_enable = 16'h0000;
    R0_15_out    = 16'h0000;
    opcode       = 5'b00000;
    halted       = 1'b0;
    case (state_q)
      S_T0: begin
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        Z_enable   = 1'b1;
      end
      S_T1: begin
        ZLowout    = 1'b1;
        PC_enable  = 1'b1;
        Read       = 1'b1;
        MDR_enable = 1'b1;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        R0_15_out = 16'h8000 >> lat_rb;
        Y_enable  = 1'b1;
      end
      S_T4: begin
        R0_15_out = 16'h8000 >> lat_rc;
        opcode    = lat_op;
        Z_enable  = 1'b1;
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (lat_muldiv) LO_enable    = 1'b1;
        else            R0_15_enable = 16'h8000 >> lat_ra;
      end
      S_T6: begin
        ZHighout  = 1'b1;
        HI_enable = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
    end
  end

endmodule
